// File: rtl/elev_pkg.sv
// Shared elevator definitions: door FSM state encoding and small elaboration helpers.
// The elevator main FSM decodes door_state with the same DOOR_* constants.
package elev_pkg;

  localparam int DOOR_STATE_W = 2;

  typedef enum logic [DOOR_STATE_W-1:0] {
    DOOR_CLOSED  = 2'd0,
    DOOR_OPENING = 2'd1,
    DOOR_DWELL   = 2'd2,
    DOOR_CLOSING = 2'd3
  } door_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic door_is_busy(input door_state_t s);
    return s != DOOR_CLOSED;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: pulses tick for one cycle every TICK_DIV clocks; clr restarts the period so the
// next tick lands exactly TICK_DIV cycles after the clear takes effect.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (clr || cnt == LAST) begin
      cnt_next = '0;
    end
  end

  // tick is registered from the next count so it is high exactly while cnt == LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/door_ctrl.sv
// Elevator door controller: CLOSED -> OPENING -> DWELL -> CLOSING -> CLOSED, timed in whole
// seconds from a local prescaler that restarts on every state change.
module door_ctrl
  import elev_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MOVE_SEC  = 2,
  parameter int DWELL_SEC = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arrive,
  input  logic                    open_btn,
  input  logic                    close_btn,
  input  logic                    obstruct,
  output logic                    sec_tick,
  output logic                    pause,
  output logic [DOOR_STATE_W-1:0] door_state,
  output logic                    busy,
  output logic                    done
);

  localparam int SEC_MAX = max_int(MOVE_SEC, DWELL_SEC);
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam logic [SEC_W-1:0] MOVE_LAST  = SEC_W'(MOVE_SEC - 1);
  localparam logic [SEC_W-1:0] DWELL_LAST = SEC_W'(DWELL_SEC - 1);

  door_state_t      state;
  door_state_t      state_next;
  logic [SEC_W-1:0] sec_cnt;
  logic             hold;
  logic             reopen;
  logic             stroke_end;
  logic             dwell_end;
  logic             clr;
  logic             done_next;

  assign hold       = open_btn | obstruct;
  assign reopen     = obstruct | open_btn | arrive;
  assign stroke_end = sec_tick && (sec_cnt == MOVE_LAST);
  assign dwell_end  = sec_tick && (sec_cnt == DWELL_LAST);

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      DOOR_CLOSED: begin
        if (arrive || open_btn) begin
          state_next = DOOR_OPENING;
        end
      end
      DOOR_OPENING: begin
        if (stroke_end) begin
          state_next = DOOR_DWELL;
        end
      end
      DOOR_DWELL: begin
        // a held door (button or obstruction) suppresses both the timeout and close_btn
        if (!hold && (close_btn || dwell_end)) begin
          state_next = DOOR_CLOSING;
        end
      end
      DOOR_CLOSING: begin
        if (reopen) begin
          state_next = DOOR_OPENING;
        end else if (stroke_end) begin
          state_next = DOOR_CLOSED;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = DOOR_CLOSED;
      end
    endcase
  end

  // Timing restarts on any state change and is frozen at zero while the door is held open
  assign clr = (state_next != state) || (state == DOOR_DWELL && hold);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(sec_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt <= '0;
    end else if (clr) begin
      sec_cnt <= '0;
    end else if (sec_tick) begin
      sec_cnt <= sec_cnt + SEC_W'(1);
    end
  end

  // Status outputs are registered from state_next so they move with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DOOR_CLOSED;
      pause <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      pause <= (state_next == DOOR_DWELL);
      busy  <= door_is_busy(state_next);
      done  <= done_next;
    end
  end

  assign door_state = state;

endmodule

// File: tb/tb_door_ctrl.sv
// Bench for door_ctrl at TICK_DIV=4, MOVE_SEC=2, DWELL_SEC=3: timing table, corner-case
// sequences and a randomized run against an elapsed-time reference model.
module tb_door_ctrl;

  localparam int TD = 4;
  localparam int MS = 2;
  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arrive = 1'b0;
  logic       open_btn = 1'b0;
  logic       close_btn = 1'b0;
  logic       obstruct = 1'b0;
  logic       sec_tick;
  logic       pause;
  logic [1:0] door_state;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  door_ctrl #(
    .TICK_DIV (TD),
    .MOVE_SEC (MS),
    .DWELL_SEC(DS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arrive    (arrive),
    .open_btn  (open_btn),
    .close_btn (close_btn),
    .obstruct  (obstruct),
    .sec_tick  (sec_tick),
    .pause     (pause),
    .door_state(door_state),
    .busy      (busy),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       arrive;
    logic       open_btn;
    logic       close_btn;
    logic       obstruct;
    logic [1:0] st;
    logic       pause;
    logic       busy;
    logic       done;
    logic       tick;
  } vec_t;

  vec_t tbl[12];

  // reference model: state plus cycles elapsed since the timing last restarted
  int ms_st = 0;
  int ms_t = 0;
  int ms_done = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_for(input logic [1:0] s, input string name);
    int n = 0;
    while (door_state !== s && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(door_state), 32'(s));
  endtask

  task automatic restart();
    arrive = 1'b0; open_btn = 1'b0; close_btn = 1'b0; obstruct = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    arrive = 1'b1;
    step();
    arrive = 1'b0;
  endtask

  task automatic model_update();
    int nxt;
    int hold;
    if (rst) begin
      ms_st = 0; ms_t = 0; ms_done = 0;
    end else begin
      nxt = ms_st;
      ms_done = 0;
      hold = int'(open_btn | obstruct);
      case (ms_st)
        0: if (arrive || open_btn) nxt = 1;
        1: if (ms_t == MS * TD - 1) nxt = 2;
        2: if (hold == 0 && (close_btn || ms_t == DS * TD - 1)) nxt = 3;
        default: begin
          if (obstruct || open_btn || arrive) nxt = 1;
          else if (ms_t == MS * TD - 1) begin
            nxt = 0;
            ms_done = 1;
          end
        end
      endcase
      ms_t = (nxt != ms_st || (ms_st == 2 && hold != 0)) ? 0 : ms_t + 1;
      ms_st = nxt;
    end
  endtask

  initial begin
    int e;
    int c;

    tbl[0]  = '{3,  0, 0, 0, 0, 2'd0, 0, 0, 0, 0};
    tbl[1]  = '{10, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1};
    tbl[2]  = '{11, 0, 0, 0, 0, 2'd1, 0, 1, 0, 0};
    tbl[3]  = '{14, 0, 0, 0, 0, 2'd1, 0, 1, 0, 1};
    tbl[4]  = '{18, 0, 0, 0, 0, 2'd1, 0, 1, 0, 1};
    tbl[5]  = '{19, 0, 0, 0, 0, 2'd2, 1, 1, 0, 0};
    tbl[6]  = '{22, 0, 0, 0, 0, 2'd2, 1, 1, 0, 1};
    tbl[7]  = '{30, 0, 0, 0, 0, 2'd2, 1, 1, 0, 1};
    tbl[8]  = '{31, 0, 0, 0, 0, 2'd3, 0, 1, 0, 0};
    tbl[9]  = '{38, 0, 0, 0, 0, 2'd3, 0, 1, 0, 1};
    tbl[10] = '{39, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0};
    tbl[11] = '{40, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0};

    // reset held through the first three edges; cycle 3 shows reset values
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_to(tbl[i].cyc);
      chk("tbl_state", 32'(door_state), 32'(tbl[i].st));
      chk("tbl_pause", 32'(pause), 32'(tbl[i].pause));
      chk("tbl_busy",  32'(busy),  32'(tbl[i].busy));
      chk("tbl_done",  32'(done),  32'(tbl[i].done));
      chk("tbl_tick",  32'(sec_tick), 32'(tbl[i].tick));
      arrive = tbl[i].arrive; open_btn = tbl[i].open_btn;
      close_btn = tbl[i].close_btn; obstruct = tbl[i].obstruct;
      step();
      arrive = 1'b0; open_btn = 1'b0; close_btn = 1'b0; obstruct = 1'b0;
    end

    // open_btn held 20 cycles from DWELL entry
    restart();
    wait_for(2'd2, "hold_enter");
    e = cyc;
    open_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("hold_sec_cnt", 32'(dut.sec_cnt), 32'd0);
      chk("hold_state", 32'(door_state), 32'd2);
      step();
    end
    open_btn = 1'b0;
    run_to(e + 31);
    chk("hold_still_dwell", 32'(door_state), 32'd2);
    step();
    chk("hold_close_after_12", 32'(door_state), 32'd3);

    // early close
    restart();
    wait_for(2'd2, "close_enter");
    e = cyc;
    run_to(e + 2);
    close_btn = 1'b1;
    step();
    close_btn = 1'b0;
    chk("close_early", 32'(door_state), 32'd3);

    // close_btn with open_btn: open wins, timing restarts
    restart();
    wait_for(2'd2, "both_enter");
    e = cyc;
    run_to(e + 2);
    close_btn = 1'b1; open_btn = 1'b1;
    step();
    close_btn = 1'b0; open_btn = 1'b0;
    chk("open_wins", 32'(door_state), 32'd2);
    run_to(e + 14);
    chk("open_wins_dwell", 32'(door_state), 32'd2);
    step();
    chk("open_wins_close", 32'(door_state), 32'd3);

    // obstruction mid-close reopens with a full stroke
    restart();
    wait_for(2'd3, "obs_enter");
    c = cyc;
    run_to(c + 5);
    obstruct = 1'b1;
    step();
    obstruct = 1'b0;
    chk("obs_reopen", 32'(door_state), 32'd1);
    for (int k = 6; k < 14; k++) begin
      chk("obs_no_done", 32'(done), 32'd0);
      chk("obs_opening", 32'(door_state), 32'd1);
      step();
    end
    chk("obs_dwell", 32'(door_state), 32'd2);

    // reset mid-DWELL, then a fresh arrival
    restart();
    wait_for(2'd2, "rst_enter");
    e = cyc;
    run_to(e + 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_state", 32'(door_state), 32'd0);
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_tick",  32'(sec_tick), 32'd0);
    run_to(e + 8);
    arrive = 1'b1;
    step();
    arrive = 1'b0;
    chk("rst_reopen", 32'(door_state), 32'd1);
    run_to(e + 17);
    chk("rst_dwell", 32'(door_state), 32'd2);
    chk("rst_dwell_pause", 32'(pause), 32'd1);

    // obstruction coinciding with the final closing tick
    restart();
    wait_for(2'd3, "final_enter");
    c = cyc;
    run_to(c + 7);
    chk("final_tick", 32'(sec_tick), 32'd1);
    obstruct = 1'b1;
    step();
    obstruct = 1'b0;
    chk("final_reopen", 32'(door_state), 32'd1);
    chk("final_no_done", 32'(done), 32'd0);
    step();
    chk("final_no_done2", 32'(done), 32'd0);

    // randomized run against the reference model
    arrive = 1'b0; open_btn = 1'b0; close_btn = 1'b0; obstruct = 1'b0;
    rst = 1'b1;
    model_update();
    step();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      chk("rnd_state", 32'(door_state), 32'(ms_st));
      chk("rnd_pause", 32'(pause), (ms_st == 2) ? 32'd1 : 32'd0);
      chk("rnd_busy",  32'(busy),  (ms_st != 0) ? 32'd1 : 32'd0);
      chk("rnd_done",  32'(done),  32'(ms_done));
      chk("rnd_tick",  32'(sec_tick), ((ms_t % TD) == TD - 1) ? 32'd1 : 32'd0);
      rst = ($urandom_range(0, 299) == 0);
      arrive = ($urandom_range(0, 19) == 0);
      close_btn = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) open_btn = ~open_btn;
      if ($urandom_range(0, 19) == 0) obstruct = ~obstruct;
      model_update();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
